// File: rtl/conv_job_sequencer.sv
// Job-level sequencer for the convolution core: loads filter/IF/psum words from
// source memories into the core FIFOs, pulses start, then drains results.

module conv_job_stream #(
  parameter int W            = 16,
  parameter int SRC_ADDR_LEN = 8,
  parameter int CNT_LEN      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [CNT_LEN-1:0]      cnt,
  input  logic                    active,
  output logic                    src_rd,
  output logic [SRC_ADDR_LEN-1:0] src_addr,
  input  logic [W-1:0]            src_data,
  output logic                    wen,
  output logic [W-1:0]            din,
  input  logic                    full,
  output logic                    done
);

  logic [CNT_LEN-1:0]      remaining;
  logic [SRC_ADDR_LEN-1:0] addr;
  logic                    rd_q;
  logic [W-1:0]            mem [2];
  logic                    wr_ptr;
  logic                    rd_ptr;
  logic [1:0]              count;
  logic                    pop;
  logic [2:0]              level;

  // level counts skid entries plus the read in flight, after this cycle's pop;
  // keeping it below 2 before a read guarantees the skid never overflows.
  assign pop      = (count != 2'd0) && !full;
  assign level    = {1'b0, count} + {2'b00, rd_q} - {2'b00, pop};
  assign src_rd   = active && (remaining != '0) && (level < 3'd2);
  assign src_addr = addr;
  assign wen      = pop;
  assign din      = mem[rd_ptr];
  assign done     = (remaining == '0) && (level == 3'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      remaining <= '0;
      addr      <= '0;
      rd_q      <= 1'b0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= 2'd0;
    end else begin
      if (load) begin
        remaining <= cnt;
        addr      <= '0;
      end else if (src_rd) begin
        remaining <= remaining - 1'b1;
        addr      <= addr + 1'b1;
      end
      rd_q <= src_rd;
      if (rd_q) wr_ptr <= ~wr_ptr;
      if (pop) rd_ptr <= ~rd_ptr;
      count <= level[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rd_q) mem[wr_ptr] <= src_data;
  end

endmodule

module conv_job_sequencer #(
  parameter int IF_SCRATCH_WIDTH    = 16,
  parameter int FILT_SCRATCH_WIDTH  = 16,
  parameter int P_SUM_SCRATCH_WIDTH = 32,
  parameter int FILT_ADDR_LEN       = 4,
  parameter int IF_ADDR_LEN         = 4,
  parameter int SRC_ADDR_LEN        = 8,
  parameter int CNT_LEN             = 8,
  parameter int START_FIRST         = 0
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       job_valid,
  output logic                                       job_ready,
  input  logic [CNT_LEN-1:0]                         job_if_cnt,
  input  logic [CNT_LEN-1:0]                         job_filt_cnt,
  input  logic [CNT_LEN-1:0]                         job_psum_cnt,
  input  logic [CNT_LEN-1:0]                         job_out_cnt,
  input  logic [FILT_ADDR_LEN-1:0]                   job_filt_len,
  input  logic [IF_ADDR_LEN-1:0]                     job_stride_len,
  input  logic [1:0]                                 job_calc_mod,
  input  logic                                       job_just_add,
  output logic                                       if_src_rd,
  output logic [SRC_ADDR_LEN-1:0]                    if_src_addr,
  input  logic [IF_SCRATCH_WIDTH+1:0]                if_src_data,
  output logic                                       filt_src_rd,
  output logic [SRC_ADDR_LEN-1:0]                    filt_src_addr,
  input  logic [FILT_SCRATCH_WIDTH-1:0]              filt_src_data,
  output logic                                       psum_src_rd,
  output logic [SRC_ADDR_LEN-1:0]                    psum_src_addr,
  input  logic [P_SUM_SCRATCH_WIDTH-1:0]             psum_src_data,
  output logic                                       IF_wen,
  output logic [IF_SCRATCH_WIDTH+1:0]                IF_din,
  input  logic                                       IF_full,
  output logic                                       filter_wen,
  output logic [FILT_SCRATCH_WIDTH-1:0]              filter_din,
  input  logic                                       filter_full,
  output logic                                       psum_buf_wen,
  output logic [P_SUM_SCRATCH_WIDTH-1:0]             P_sum_buff_inp,
  input  logic                                       psum_buf_full,
  output logic                                       start,
  output logic [FILT_ADDR_LEN-1:0]                   filt_len,
  output logic [IF_ADDR_LEN-1:0]                     stride_len,
  output logic [1:0]                                 calc_mod,
  output logic                                       just_add_flag,
  output logic                                       outbuf_ren,
  input  logic [IF_SCRATCH_WIDTH+FILT_SCRATCH_WIDTH-1:0] outbuf_dout,
  input  logic                                       outbuf_empty,
  output logic                                       res_valid,
  input  logic                                       res_ready,
  output logic [IF_SCRATCH_WIDTH+FILT_SCRATCH_WIDTH-1:0] res_data,
  output logic                                       busy,
  output logic                                       done,
  output logic [2:0]                                 dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PRE_START = 3'd1,
    S_LOAD      = 3'd2,
    S_START     = 3'd3,
    S_DRAIN     = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               accept;
  logic               load_active;
  logic               if_done;
  logic               filt_done;
  logic               psum_done;
  logic               load_done;
  logic               drain_done;
  logic [CNT_LEN-1:0] out_rem;

  // Handshakes (job, result): a transfer happens in a cycle where valid and
  // ready are both high; valid never drops and data never changes while the
  // transfer is pending.
  assign job_ready   = (state == S_IDLE);
  assign accept      = job_valid && job_ready;
  assign load_active = (state == S_LOAD);
  assign load_done   = if_done && filt_done && psum_done;
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);
  assign dbg_state   = state;

  conv_job_stream #(
    .W(IF_SCRATCH_WIDTH + 2), .SRC_ADDR_LEN(SRC_ADDR_LEN), .CNT_LEN(CNT_LEN)
  ) u_if_stream (
    .clk(clk), .rst(rst), .load(accept), .cnt(job_if_cnt), .active(load_active),
    .src_rd(if_src_rd), .src_addr(if_src_addr), .src_data(if_src_data),
    .wen(IF_wen), .din(IF_din), .full(IF_full), .done(if_done)
  );

  conv_job_stream #(
    .W(FILT_SCRATCH_WIDTH), .SRC_ADDR_LEN(SRC_ADDR_LEN), .CNT_LEN(CNT_LEN)
  ) u_filt_stream (
    .clk(clk), .rst(rst), .load(accept), .cnt(job_filt_cnt), .active(load_active),
    .src_rd(filt_src_rd), .src_addr(filt_src_addr), .src_data(filt_src_data),
    .wen(filter_wen), .din(filter_din), .full(filter_full), .done(filt_done)
  );

  conv_job_stream #(
    .W(P_SUM_SCRATCH_WIDTH), .SRC_ADDR_LEN(SRC_ADDR_LEN), .CNT_LEN(CNT_LEN)
  ) u_psum_stream (
    .clk(clk), .rst(rst), .load(accept), .cnt(job_psum_cnt), .active(load_active),
    .src_rd(psum_src_rd), .src_addr(psum_src_addr), .src_data(psum_src_data),
    .wen(psum_buf_wen), .din(P_sum_buff_inp), .full(psum_buf_full), .done(psum_done)
  );

  // A result accepted this cycle counts as drained, so done follows the last
  // result handshake by exactly one cycle.
  assign outbuf_ren = (state == S_DRAIN) && (out_rem != '0) && !outbuf_empty &&
                      (!res_valid || res_ready);
  assign drain_done = (out_rem == '0) && (!res_valid || res_ready);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (job_valid) state_nxt = (START_FIRST != 0) ? S_PRE_START : S_LOAD;
      S_PRE_START: state_nxt = S_LOAD;
      S_LOAD:      if (load_done) state_nxt = (START_FIRST != 0) ? S_DRAIN : S_START;
      S_START:     state_nxt = S_DRAIN;
      S_DRAIN:     if (drain_done) state_nxt = S_DONE;
      S_DONE:      state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      start <= 1'b0;
    end else begin
      state <= state_nxt;
      start <= (state_nxt == S_PRE_START) || (state_nxt == S_START);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      filt_len      <= '0;
      stride_len    <= '0;
      calc_mod      <= 2'd0;
      just_add_flag <= 1'b0;
      out_rem       <= '0;
      res_valid     <= 1'b0;
      res_data      <= '0;
    end else begin
      if (accept) begin
        filt_len      <= job_filt_len;
        stride_len    <= job_stride_len;
        calc_mod      <= job_calc_mod;
        just_add_flag <= job_just_add;
        out_rem       <= job_out_cnt;
      end else if (outbuf_ren) begin
        out_rem <= out_rem - 1'b1;
      end
      if (outbuf_ren) begin
        res_data  <= outbuf_dout;
        res_valid <= 1'b1;
      end else if (res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_job_sequencer.sv
// Directed bench for conv_job_sequencer: per-stream word order, start/done
// timing, FIFO and result backpressure, zero counts, accumulate jobs, reset.

module tb_conv_job_sequencer;

  logic        clk;
  logic        rst;
  logic        job_valid, job_ready, job_valid_b, job_ready_b;
  logic [7:0]  job_if_cnt, job_filt_cnt, job_psum_cnt, job_out_cnt;
  logic [3:0]  job_filt_len, job_stride_len;
  logic [1:0]  job_calc_mod;
  logic        job_just_add;

  logic        if_src_rd, filt_src_rd, psum_src_rd;
  logic [7:0]  if_src_addr, filt_src_addr, psum_src_addr;
  logic [17:0] if_src_data = '0;
  logic [15:0] filt_src_data = '0;
  logic [31:0] psum_src_data = '0;
  logic        IF_wen, filter_wen, psum_buf_wen;
  logic [17:0] IF_din;
  logic [15:0] filter_din;
  logic [31:0] P_sum_buff_inp;
  logic        IF_full, filter_full, psum_buf_full;
  logic        start, just_add_flag, outbuf_ren, outbuf_empty;
  logic [3:0]  filt_len, stride_len;
  logic [1:0]  calc_mod;
  logic [31:0] outbuf_dout, res_data;
  logic        res_valid, res_ready, busy, done;
  logic [2:0]  dbg_state;

  logic        if_src_rd_b, filt_src_rd_b, psum_src_rd_b;
  logic [7:0]  if_src_addr_b, filt_src_addr_b, psum_src_addr_b;
  logic        IF_wen_b, filter_wen_b, psum_buf_wen_b;
  logic [17:0] IF_din_b;
  logic [15:0] filter_din_b;
  logic [31:0] P_sum_buff_inp_b, res_data_b;
  logic        start_b, just_add_flag_b, outbuf_ren_b, res_valid_b, busy_b, done_b;
  logic [3:0]  filt_len_b, stride_len_b;
  logic [1:0]  calc_mod_b;
  logic [2:0]  dbg_state_b;

  int ob_provided;
  int ob_popped = 0;

  int cyc, errors, checks;
  int if_wr, filt_wr, psum_wr, if_first, if_last, filt_last, psum_last, last_wr;
  int start_n, start_cyc, done_n, done_cyc, ren_n, res_n, res_tot;
  int first_hs, last_hs, stall_n, acc_cyc;
  int start_b_n, start_b_cyc, done_b_n, acc_b, jaf_changes, jaf_chg_cyc;
  logic jaf_prev;

  function automatic logic [17:0] if_word(input int i);
    return {2'b10, 16'h1000 + 16'(i)};
  endfunction
  function automatic logic [15:0] filt_word(input int i);
    return 16'h2000 + 16'(i);
  endfunction
  function automatic logic [31:0] psum_word(input int i);
    return 32'h3000_0000 + 32'(i);
  endfunction
  function automatic logic [31:0] ob_word(input int i);
    return 32'hA5A5_0000 + 32'(i);
  endfunction

  conv_job_sequencer #(.START_FIRST(0)) u_dut (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
    .job_if_cnt(job_if_cnt), .job_filt_cnt(job_filt_cnt), .job_psum_cnt(job_psum_cnt),
    .job_out_cnt(job_out_cnt), .job_filt_len(job_filt_len), .job_stride_len(job_stride_len),
    .job_calc_mod(job_calc_mod), .job_just_add(job_just_add),
    .if_src_rd(if_src_rd), .if_src_addr(if_src_addr), .if_src_data(if_src_data),
    .filt_src_rd(filt_src_rd), .filt_src_addr(filt_src_addr), .filt_src_data(filt_src_data),
    .psum_src_rd(psum_src_rd), .psum_src_addr(psum_src_addr), .psum_src_data(psum_src_data),
    .IF_wen(IF_wen), .IF_din(IF_din), .IF_full(IF_full),
    .filter_wen(filter_wen), .filter_din(filter_din), .filter_full(filter_full),
    .psum_buf_wen(psum_buf_wen), .P_sum_buff_inp(P_sum_buff_inp), .psum_buf_full(psum_buf_full),
    .start(start), .filt_len(filt_len), .stride_len(stride_len), .calc_mod(calc_mod),
    .just_add_flag(just_add_flag), .outbuf_ren(outbuf_ren), .outbuf_dout(outbuf_dout),
    .outbuf_empty(outbuf_empty), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // Second instance with start issued before the load phase.
  conv_job_sequencer #(.START_FIRST(1)) u_dut_sf (
    .clk(clk), .rst(rst), .job_valid(job_valid_b), .job_ready(job_ready_b),
    .job_if_cnt(job_if_cnt), .job_filt_cnt(job_filt_cnt), .job_psum_cnt(job_psum_cnt),
    .job_out_cnt(job_out_cnt), .job_filt_len(job_filt_len), .job_stride_len(job_stride_len),
    .job_calc_mod(job_calc_mod), .job_just_add(job_just_add),
    .if_src_rd(if_src_rd_b), .if_src_addr(if_src_addr_b), .if_src_data(18'h0),
    .filt_src_rd(filt_src_rd_b), .filt_src_addr(filt_src_addr_b), .filt_src_data(16'h0),
    .psum_src_rd(psum_src_rd_b), .psum_src_addr(psum_src_addr_b), .psum_src_data(32'h0),
    .IF_wen(IF_wen_b), .IF_din(IF_din_b), .IF_full(1'b0),
    .filter_wen(filter_wen_b), .filter_din(filter_din_b), .filter_full(1'b0),
    .psum_buf_wen(psum_buf_wen_b), .P_sum_buff_inp(P_sum_buff_inp_b), .psum_buf_full(1'b0),
    .start(start_b), .filt_len(filt_len_b), .stride_len(stride_len_b), .calc_mod(calc_mod_b),
    .just_add_flag(just_add_flag_b), .outbuf_ren(outbuf_ren_b), .outbuf_dout(32'h0BAD_0000),
    .outbuf_empty(1'b0), .res_valid(res_valid_b), .res_ready(1'b1),
    .res_data(res_data_b), .busy(busy_b), .done(done_b), .dbg_state(dbg_state_b)
  );

  // Clock, source memories (1-cycle read latency) and FWFT output buffer.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (if_src_rd)   if_src_data   <= if_word(int'(if_src_addr));
    if (filt_src_rd) filt_src_data <= filt_word(int'(filt_src_addr));
    if (psum_src_rd) psum_src_data <= psum_word(int'(psum_src_addr));
    if (outbuf_ren)  ob_popped     <= ob_popped + 1;
  end

  assign outbuf_empty = (ob_popped >= ob_provided);
  assign outbuf_dout  = ob_word(ob_popped);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic sample();
    if (job_valid && job_ready) acc_cyc = cyc;
    if (job_valid_b && job_ready_b) acc_b = cyc;
    if (IF_full) check("if_wen_while_full", 64'(IF_wen), 64'd0);
    if (IF_wen) begin
      check("if_word", 64'(IF_din), 64'(if_word(if_wr)));
      if (if_wr == 0) if_first = cyc;
      if_wr++; if_last = cyc; last_wr = cyc;
    end
    if (filter_wen) begin
      check("filt_word", 64'(filter_din), 64'(filt_word(filt_wr)));
      filt_wr++; filt_last = cyc; last_wr = cyc;
    end
    if (psum_buf_wen) begin
      check("psum_word", 64'(P_sum_buff_inp), 64'(psum_word(psum_wr)));
      psum_wr++; psum_last = cyc; last_wr = cyc;
    end
    if (start) begin start_n++; start_cyc = cyc; end
    if (done) begin done_n++; done_cyc = cyc; end
    if (outbuf_ren) ren_n++;
    if (res_valid && !res_ready) begin
      stall_n++;
      check("ren_while_stalled", 64'(outbuf_ren), 64'd0);
      check("res_data_held", 64'(res_data), 64'(ob_word(res_tot)));
    end
    if (res_valid && res_ready) begin
      check("res_data", 64'(res_data), 64'(ob_word(res_tot)));
      if (res_n == 0) first_hs = cyc;
      res_n++; res_tot++; last_hs = cyc;
    end
    if (start_b) begin start_b_n++; start_b_cyc = cyc; end
    if (done_b) done_b_n++;
    if (just_add_flag_b !== jaf_prev) begin jaf_changes++; jaf_chg_cyc = cyc; end
    jaf_prev = just_add_flag_b;
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic set_job(input int nif, input int nfilt, input int npsum, input int nout,
                         input logic [3:0] fl, input logic [3:0] sl, input logic [1:0] cm,
                         input logic ja);
    job_if_cnt = 8'(nif); job_filt_cnt = 8'(nfilt); job_psum_cnt = 8'(npsum);
    job_out_cnt = 8'(nout); job_filt_len = fl; job_stride_len = sl;
    job_calc_mod = cm; job_just_add = ja;
  endtask

  // mode: 0 plain, 1 IF_full burst after 4th IF write, 2 result stall, 3 reset mid-load
  task automatic run_job(input int nif, input int nfilt, input int npsum, input int nout,
                         input logic [3:0] fl, input logic [3:0] sl, input logic [1:0] cm,
                         input logic ja, input int mode);
    int n = 0;
    int hold = 0;
    bit bp_done = 0;
    bit abort = 0;
    if_wr = 0; filt_wr = 0; psum_wr = 0; start_n = 0; done_n = 0;
    ren_n = 0; res_n = 0; stall_n = 0;
    ob_provided = ob_popped + nout;
    set_job(nif, nfilt, npsum, nout, fl, sl, cm, ja);
    check("job_ready_idle", 64'(job_ready), 64'd1);
    res_ready = (mode != 2);
    job_valid = 1'b1;
    tick();
    job_valid = 1'b0;
    while (done_n == 0 && n < 400 && !abort) begin
      if (mode == 1 && if_wr == 4 && !bp_done) begin hold = 5; bp_done = 1; end
      IF_full = (hold > 0);
      if (mode == 2 && stall_n >= 3) res_ready = 1'b1;
      if (mode == 3 && if_wr >= 3) begin
        abort = 1;
      end else begin
        check("job_ready_busy", 64'(job_ready), 64'd0);
        tick();
        if (hold > 0) hold--;
        n++;
      end
    end
    IF_full = 1'b0;
    res_ready = 1'b1;
    if (abort) begin
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_if_wen", 64'(IF_wen), 64'd0);
      check("rst_filt_wen", 64'(filter_wen), 64'd0);
      check("rst_psum_wen", 64'(psum_buf_wen), 64'd0);
      check("rst_start", 64'(start), 64'd0);
      check("rst_ren", 64'(outbuf_ren), 64'd0);
      check("rst_job_ready", 64'(job_ready), 64'd1);
      check("rst_busy", 64'(busy), 64'd0);
    end else begin
      check("job_done_seen", 64'(done_n), 64'd1);
    end
  endtask

  initial begin
    cyc = 0; errors = 0; checks = 0; res_tot = 0; jaf_prev = 1'b0;
    jaf_changes = 0; done_b_n = 0; start_b_n = 0; ob_provided = 0;
    rst = 1'b1; job_valid = 1'b0; job_valid_b = 1'b0;
    IF_full = 1'b0; filter_full = 1'b0; psum_buf_full = 1'b0; res_ready = 1'b1;
    set_job(0, 0, 0, 0, 4'd0, 4'd0, 2'd0, 1'b0);
    @(posedge clk); #1;
    tick(); tick();

    check("reset_job_ready", 64'(job_ready), 64'd1);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_start", 64'(start), 64'd0);
    check("reset_if_wen", 64'(IF_wen), 64'd0);
    check("reset_if_rd", 64'(if_src_rd), 64'd0);
    check("reset_ren", 64'(outbuf_ren), 64'd0);
    check("reset_res_valid", 64'(res_valid), 64'd0);
    check("reset_res_data", 64'(res_data), 64'd0);
    check("reset_filt_len", 64'(filt_len), 64'd0);
    rst = 1'b0;
    tick();

    // Basic job: IF 11, filt 6, psum 10, out 12
    run_job(11, 6, 10, 12, 4'd3, 4'd1, 2'd2, 1'b0, 0);
    check("basic_if_count", 64'(if_wr), 64'd11);
    check("basic_filt_count", 64'(filt_wr), 64'd6);
    check("basic_psum_count", 64'(psum_wr), 64'd10);
    check("basic_first_wen", 64'(if_first - acc_cyc), 64'd3);
    check("basic_start_count", 64'(start_n), 64'd1);
    check("basic_start_after_wr", 64'(start_cyc - last_wr), 64'd1);
    check("basic_start_cycle", 64'(start_cyc - acc_cyc), 64'd14);
    check("basic_ren_count", 64'(ren_n), 64'd12);
    check("basic_res_count", 64'(res_n), 64'd12);
    check("basic_done_after_hs", 64'(done_cyc - last_hs), 64'd1);
    check("basic_done_cycle", 64'(done_cyc - acc_cyc), 64'd28);
    check("basic_filt_len", 64'(filt_len), 64'd3);
    check("basic_stride_len", 64'(stride_len), 64'd1);
    check("basic_calc_mod", 64'(calc_mod), 64'd2);

    // IF FIFO full for 5 cycles after 4th IF write
    run_job(11, 6, 10, 4, 4'd3, 4'd1, 2'd2, 1'b0, 1);
    check("bp_if_count", 64'(if_wr), 64'd11);
    check("bp_if_last", 64'(if_last - acc_cyc), 64'd18);
    check("bp_filt_last", 64'(filt_last - acc_cyc), 64'd8);
    check("bp_psum_last", 64'(psum_last - acc_cyc), 64'd12);
    check("bp_start_cycle", 64'(start_cyc - acc_cyc), 64'd19);

    // Zero psum and out counts
    run_job(4, 3, 0, 0, 4'd2, 4'd2, 2'd1, 1'b0, 0);
    check("zero_psum_wen", 64'(psum_wr), 64'd0);
    check("zero_ren", 64'(ren_n), 64'd0);
    check("zero_if_count", 64'(if_wr), 64'd4);
    check("zero_done_after_start", 64'(done_cyc - start_cyc), 64'd2);

    // Result backpressure: 3 stalled cycles then one result per cycle
    run_job(2, 2, 2, 6, 4'd1, 4'd1, 2'd0, 1'b0, 2);
    check("rbp_stall_cycles", 64'(stall_n), 64'd3);
    check("rbp_ren_count", 64'(ren_n), 64'd6);
    check("rbp_res_count", 64'(res_n), 64'd6);
    check("rbp_release_rate", 64'(last_hs - first_hs), 64'd5);

    // Back-to-back accumulate jobs on the start-first instance
    set_job(2, 2, 2, 2, 4'd2, 4'd1, 2'd1, 1'b0);
    check("b_job_ready_idle", 64'(job_ready_b), 64'd1);
    job_valid_b = 1'b1;
    tick();
    job_valid_b = 1'b0;
    for (int n = 0; n < 200 && done_b_n < 1; n++) begin
      check("b_job_ready_busy", 64'(job_ready_b), 64'd0);
      tick();
    end
    check("b_first_done", 64'(done_b_n), 64'd1);
    check("b_first_start", 64'(start_b_cyc - acc_b), 64'd1);
    check("b_first_start_count", 64'(start_b_n), 64'd1);
    check("b_jaf_unchanged", 64'(jaf_changes), 64'd0);
    set_job(2, 2, 2, 2, 4'd2, 4'd1, 2'd1, 1'b1);
    check("b_job_ready_after_done", 64'(job_ready_b), 64'd1);
    job_valid_b = 1'b1;
    tick();
    job_valid_b = 1'b0;
    for (int n = 0; n < 200 && done_b_n < 2; n++) begin
      check("b_job_ready_busy2", 64'(job_ready_b), 64'd0);
      tick();
    end
    check("b_second_done", 64'(done_b_n), 64'd2);
    check("b_second_start", 64'(start_b_cyc - acc_b), 64'd1);
    check("b_start_count", 64'(start_b_n), 64'd2);
    check("b_jaf_changes", 64'(jaf_changes), 64'd1);
    check("b_jaf_change_cycle", 64'(jaf_chg_cyc - acc_b), 64'd1);
    check("b_jaf_value", 64'(just_add_flag_b), 64'd1);

    // Reset mid-load, then a fresh job restarts from address 0
    run_job(8, 8, 8, 2, 4'd1, 4'd1, 2'd0, 1'b0, 3);
    tick();
    run_job(3, 2, 2, 2, 4'd1, 4'd1, 2'd0, 1'b0, 0);
    check("rst_new_if_count", 64'(if_wr), 64'd3);
    check("rst_new_filt_count", 64'(filt_wr), 64'd2);
    check("rst_new_psum_count", 64'(psum_wr), 64'd2);
    check("rst_new_res_count", 64'(res_n), 64'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
